// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state type and constants for the UART receive controller.
// Parity support in the controller is compiled in with UART_RX_PARITY_EN.
package uart_rx_pkg;

    localparam int BIT_CNT_W      = 4;
    localparam int DEF_DATA_WIDTH = 8;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

endpackage

// File: rtl/edge_bit_counter.sv
// edge_bit_counter: oversampling edge counter and bit-position counter.
// bit_end marks the last oversampling edge of the current bit.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
)
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_enable,
    input  logic                 i_clear,
    input  logic                 i_bit_hold,
    input  logic [PRESC_W-1:0]   i_presc,
    output logic [PRESC_W-1:0]   o_edge_count,
    output logic [BIT_CNT_W-1:0] o_bit_count,
    output logic                 o_bit_end
);

    logic [PRESC_W-1:0]   r_edge;
    logic [BIT_CNT_W-1:0] r_bit;
    logic                 w_bit_end;

    assign w_bit_end    = i_enable && (r_edge == i_presc - PRESC_W'(1));
    assign o_edge_count = r_edge;
    assign o_bit_count  = r_bit;
    assign o_bit_end    = w_bit_end;

    // Edge counter wraps at bit end; bit counter advances unless held.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge <= '0;
            r_bit  <= '0;
        end else if (i_clear) begin
            r_edge <= '0;
            r_bit  <= '0;
        end else if (i_enable) begin
            if (w_bit_end) begin
                r_edge <= '0;
                if (!i_bit_hold) begin
                    r_bit <= r_bit + BIT_CNT_W'(1);
                end
            end else begin
                r_edge <= r_edge + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer, bit checks and strobes.
// Define UART_RX_PARITY_EN to add PAR_EN/PAR_TYP, the PARITY state and par_err.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESC_W    = 6
)
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_IN,
    input  logic [PRESC_W-1:0]   Prescale,
`ifdef UART_RX_PARITY_EN
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
`endif
    input  logic                 Sampled_Bit,
    output logic                 data_samp_en,
    output logic [PRESC_W-1:0]   edge_count,
    output logic [BIT_CNT_W-1:0] bit_count,
    output logic                 deser_en,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 stp_err
);

    rx_state_e          r_state;
    rx_state_e          w_next;
    logic [PRESC_W-1:0] r_presc;

    logic w_bit_end;
    logic w_busy;
    logic w_next_busy;
    logic w_start;
    logic w_hold;
    logic w_last_data;
    logic w_pre_end;
    logic w_stp_bad;

    logic r_samp_en;
    logic r_deser_en;
    logic r_data_valid;
    logic r_stp_err;
    logic r_ferr;

`ifdef UART_RX_PARITY_EN
    logic r_acc;
    logic r_par_err;
    logic w_par_bad;

    assign w_par_bad = Sampled_Bit != (r_acc ^ PAR_TYP);
    assign par_err   = r_par_err;
`else
    assign par_err   = 1'b0;
`endif

    assign w_busy      = r_state inside {START, DATA, PARITY, STOP};
    assign w_next_busy = w_next inside {START, DATA, PARITY, STOP};
    assign w_start     = (r_state inside {IDLE, DONE}) && !RX_IN;
    assign w_last_data = bit_count == BIT_CNT_W'(DATA_WIDTH);
    assign w_stp_bad   = !Sampled_Bit;
    assign w_hold      = w_bit_end &&
                         ((r_state == START && Sampled_Bit) ||
                          r_state == STOP);
    // deser_en is registered one edge early so it lands on the bit end.
    assign w_pre_end   = (r_state == DATA) &&
                         (edge_count == r_presc - PRESC_W'(2));

    assign data_samp_en = r_samp_en;
    assign deser_en     = r_deser_en;
    assign data_valid   = r_data_valid;
    assign stp_err      = r_stp_err;

    edge_bit_counter #(
        .PRESC_W      (PRESC_W)
    ) u_cnt (
        .CLK          (CLK),
        .RST          (RST),
        .i_enable     (w_busy),
        .i_clear      (!w_busy),
        .i_bit_hold   (w_hold),
        .i_presc      (r_presc),
        .o_edge_count (edge_count),
        .o_bit_count  (bit_count),
        .o_bit_end    (w_bit_end)
    );

    // State register and prescale latch at each frame start.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_presc <= PRESC_W'(PRESC_8);
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_presc <= Prescale;
            end
        end
    end

    // Next-state decode, advancing only on bit ends inside a frame.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!RX_IN) w_next = START;
            end
            START: begin
                if (w_bit_end) w_next = Sampled_Bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_bit_end && w_last_data) begin
`ifdef UART_RX_PARITY_EN
                    w_next = PAR_EN ? PARITY : STOP;
`else
                    w_next = STOP;
`endif
                end
            end
            PARITY: begin
                if (w_bit_end) w_next = STOP;
            end
            STOP: begin
                if (w_bit_end) w_next = DONE;
            end
            DONE: begin
                w_next = RX_IN ? IDLE : START;
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered enables, bit checks, error flag and strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samp_en    <= 1'b0;
            r_deser_en   <= 1'b0;
            r_data_valid <= 1'b0;
            r_stp_err    <= 1'b0;
            r_ferr       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_acc        <= 1'b0;
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_samp_en    <= w_next_busy;
            r_deser_en   <= w_pre_end;
            r_data_valid <= 1'b0;
            r_stp_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err    <= 1'b0;
            if (r_state == DATA && w_bit_end) begin
                r_acc <= r_acc ^ Sampled_Bit;
            end
            if (r_state == PARITY && w_bit_end && w_par_bad) begin
                r_par_err <= 1'b1;
                r_ferr    <= 1'b1;
            end
            if (r_state == DONE) begin
                r_acc <= 1'b0;
            end
`endif
            if (r_state == STOP && w_bit_end) begin
                if (w_stp_bad) begin
                    r_stp_err <= 1'b1;
                    r_ferr    <= 1'b1;
                end else if (!r_ferr) begin
                    r_deser_en   <= 1'b1;
                    r_data_valid <= 1'b1;
                end
            end
            if (r_state == DONE) begin
                r_ferr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames with a scoreboard of expected strobes.
// Parity frames are exercised only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int EV_BIT   = 0;
    localparam int EV_VALID = 1;
    localparam int EV_PERR  = 2;
    localparam int EV_SERR  = 3;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       Sampled_Bit;
`ifdef UART_RX_PARITY_EN
    logic       PAR_EN;
    logic       PAR_TYP;
`endif
    logic       data_samp_en;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       deser_en;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    ev_t        q[$];
    int         dv_cyc[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         n_deser = 0;
    int         presc_tb = 8;
    logic [7:0] rx_byte = 8'h00;

    uart_rx_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
`ifdef UART_RX_PARITY_EN
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
`endif
        .Sampled_Bit  (Sampled_Bit),
        .data_samp_en (data_samp_en),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .deser_en     (deser_en),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    always #5 CLK = ~CLK;

    // Sampler model: captures the line at mid-bit while enabled.
    always @(posedge CLK or negedge RST) begin
        if (!RST) Sampled_Bit <= 1'b1;
        else if (data_samp_en && edge_count == 6'(presc_tb / 2))
            Sampled_Bit <= RX_IN;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic pop_check(input int kind, input int a, input int b,
                             input string nm);
        ev_t e;
        if (q.size() == 0) begin
            n_total++;
            $display("FAIL %s: unexpected event kind %0d at cycle %0d",
                     nm, kind, cyc);
            return;
        end
        e = q.pop_front();
        chk({nm, " kind"}, kind, e.kind);
        chk({nm, " value"}, a, e.a);
        if (kind == EV_BIT) chk({nm, " bit"}, b, e.b);
    endtask

    // Monitor: every strobe from the DUT must match the next expected event.
    always @(negedge CLK) begin
        if (RST) begin
            cyc++;
            if (deser_en) n_deser++;
            if (deser_en && !data_valid) begin
                if (bit_count >= 1 && bit_count <= 8)
                    rx_byte[bit_count - 1] = Sampled_Bit;
                chk("deser at bit end", int'(edge_count), presc_tb - 1);
                pop_check(EV_BIT, int'(bit_count), int'(Sampled_Bit),
                          "deser bit");
            end
            if (data_valid) begin
                dv_cyc.push_back(cyc);
                chk("deser with valid", int'(deser_en), 1);
                pop_check(EV_VALID, int'(rx_byte), 0, "data_valid");
            end
            if (par_err) pop_check(EV_PERR, 0, 0, "par_err");
            if (stp_err) pop_check(EV_SERR, 0, 0, "stp_err");
        end
    end

    task automatic push_ev(input int k, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        q.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] d, input bit ok,
                              input bit pe, input bit se);
        for (int i = 1; i <= 8; i++) push_ev(EV_BIT, i, int'(d[i-1]));
        if (pe) push_ev(EV_PERR, 0, 0);
        if (se) push_ev(EV_SERR, 0, 0);
        if (ok) push_ev(EV_VALID, int'(d), 0);
    endtask

    task automatic send_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p,
                              input bit pen, input bit pbit,
                              input bit stop);
        presc_tb = p;
        Prescale = 6'(p);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (pen) send_bit(pbit, p);
        send_bit(stop, p);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " data_samp_en"}, int'(data_samp_en), 0);
        chk({tag, " deser_en"}, int'(deser_en), 0);
        chk({tag, " data_valid"}, int'(data_valid), 0);
        chk({tag, " par_err"}, int'(par_err), 0);
        chk({tag, " stp_err"}, int'(stp_err), 0);
        chk({tag, " edge_count"}, int'(edge_count), 0);
        chk({tag, " bit_count"}, int'(bit_count), 0);
    endtask

    initial begin
        int n0;
        int nd;
        logic [7:0] ab;
        RST = 1'b0;
        RX_IN = 1'b1;
        Prescale = 6'(PRESC_8);
`ifdef UART_RX_PARITY_EN
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        RST = 1'b1;
        idle(4);

        push_frame(8'hA5, 1, 0, 0);
        send_frame(8'hA5, PRESC_8, 0, 0, 1);
        idle(24);
        chk("A5 drained", q.size(), 0);

        push_frame(8'h3C, 1, 0, 0);
        push_frame(8'hC3, 1, 0, 0);
        send_frame(8'h3C, PRESC_16, 0, 0, 1);
        send_frame(8'hC3, PRESC_16, 0, 0, 1);
        idle(40);
        chk("b2b drained", q.size(), 0);
        nd = dv_cyc.size();
        chk("b2b spacing",
            nd >= 2 ? dv_cyc[nd-1] - dv_cyc[nd-2] : -1, 161);

        push_frame(8'h81, 0, 0, 1);
        send_frame(8'h81, PRESC_32, 0, 0, 0);
        idle(4);
        chk("stp idle samp_en", int'(data_samp_en), 0);
        chk("stp idle bit_count", int'(bit_count), 0);
        idle(60);
        chk("stp drained", q.size(), 0);

        n0 = n_deser;
        nd = dv_cyc.size();
        presc_tb = PRESC_8;
        Prescale = 6'(PRESC_8);
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        idle(24);
        chk("glitch deser", n_deser - n0, 0);
        chk("glitch valid", dv_cyc.size() - nd, 0);
        chk("glitch samp_en", int'(data_samp_en), 0);
        chk("glitch drained", q.size(), 0);

`ifdef UART_RX_PARITY_EN
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        push_frame(8'h0F, 1, 0, 0);
        send_frame(8'h0F, PRESC_16, 1, 0, 1);
        idle(40);
        push_frame(8'h0F, 0, 1, 0);
        send_frame(8'h0F, PRESC_16, 1, 1, 1);
        idle(40);
        chk("parity drained", q.size(), 0);
        PAR_EN = 1'b0;
`endif

        ab = 8'h96;
        for (int i = 1; i <= 3; i++) push_ev(EV_BIT, i, int'(ab[i-1]));
        presc_tb = PRESC_8;
        Prescale = 6'(PRESC_8);
        send_bit(1'b0, PRESC_8);
        for (int i = 0; i < 3; i++) send_bit(ab[i], PRESC_8);
        RX_IN = ab[3];
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_zero("mid reset");
        chk("abort drained", q.size(), 0);
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        RST = 1'b1;
        idle(8);
        push_frame(8'h55, 1, 0, 0);
        send_frame(8'h55, PRESC_8, 0, 0, 1);
        idle(24);
        chk("55 drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-sequencing controller for the UART receiver. It detects the start bit on RX_IN and counts oversampling edges and bit positions. It drives the sampler and Deserializer enables (data_samp_en, deser_en, bit_count), checks the start, parity and stop bits, and issues the one-cycle data_valid strobe that makes the Deserializer present P_DATA. It sits between the RX pin synchroniser/sampler and the Deserializer.

## Interface
- DATA_WIDTH, 8, data bits per frame
- PRESC_W, 6, width of Prescale and edge_count
- CLK  in  1  oversampling clock
- RST  in  1  reset, asynchronous, active-low
- RX_IN  in  1  synchronised serial line, idle high
- Prescale  in  PRESC_W  oversampling ratio; legal values 8, 16, 32
- PAR_EN  in  1  parity bit present (only with UART_RX_PARITY_EN)
- PAR_TYP  in  1  0 = even, 1 = odd (only with UART_RX_PARITY_EN)
- Sampled_Bit  in  1  majority-voted bit from the sampler
- data_samp_en  out  1  sampler enable
- edge_count  out  PRESC_W  oversampling edge index within the current bit
- bit_count  out  4  bit position: 0 = start, 1..DATA_WIDTH = data, then parity, then stop
- deser_en  out  1  Deserializer write/latch enable
- data_valid  out  1  frame accepted, one-cycle strobe
- par_err  out  1  parity error, one-cycle strobe
- stp_err  out  1  framing (stop) error, one-cycle strobe

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - RX_IN==0 -> START; edge_count=0, bit_count=0.
  - Prescale is latched on this transition and held for the whole frame.
- Bit end: the cycle where edge_count == latched Prescale-1. Sampled_Bit is evaluated only at bit end.
  - edge_count then wraps to 0.
  - bit_count increments, except on the START->IDLE, STOP->DONE and DONE exits.
- START: at bit end, Sampled_Bit==1 is a glitch -> IDLE with no error strobe. Sampled_Bit==0 -> DATA, bit_count=1.
- DATA:
  - At each bit end, deser_en is high for one cycle and the parity accumulator is updated: acc ^= Sampled_Bit.
  - After bit DATA_WIDTH, go to PARITY if PAR_EN, else STOP.
- PARITY: at bit end, expected bit = acc ^ PAR_TYP. On mismatch, par_err pulses that cycle and a sticky frame-error flag is set. Next state is always STOP.
- STOP:
  - At bit end, Sampled_Bit==0 -> stp_err pulses that cycle and the frame-error flag is set.
  - Next state DONE.
- DONE, one cycle:
  - If the frame-error flag is clear, deser_en=1 and data_valid=1; otherwise both are 0.
  - The flag and acc clear.
  - RX_IN==0 -> START (back-to-back frame, Prescale re-latched). Otherwise -> IDLE.
- data_samp_en = 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- The internal parity accumulator is used; the Deserializer's parity_flag is not consumed.

## Timing
- Reset values: data_samp_en, deser_en, data_valid, par_err and stp_err are 0; edge_count and bit_count are 0. The FSM enters IDLE and acc plus the frame-error flag clear.
- Reset mid-frame aborts the frame with no strobes.
- All outputs are registered, except that bit_count and edge_count are the counter registers themselves.
- deser_en in DATA coincides with the bit_count of the bit being written, so the Deserializer writes DATA[bit_count-1].
- data_valid latency: 1 cycle after the stop-bit end cycle.
- Frame length in CLK cycles: (2 + DATA_WIDTH + PAR_EN) × Prescale, plus 1 for DONE.
- Stop-error frames still pass through DONE, giving 1-cycle resynchronisation, then IDLE or START on RX_IN.
- Simultaneous par_err and stp_err are impossible: they occur in different bit slots.
- Prescale changes mid-frame are ignored; the latched value applies.
- An illegal Prescale is not checked; behaviour follows the counter arithmetic, i.e. wrap at Prescale-1.

## Configuration
- Macro UART_RX_PARITY_EN.
- Defined: the PAR_EN/PAR_TYP ports, the PARITY state, the accumulator and par_err exist.
- Undefined: those ports and logic are absent, par_err is tied 0, and the frame is fixed 8N1 (DATA -> STOP).

## Structure
- Package uart_rx_pkg:
  - state enum;
  - BIT_CNT_W=4;
  - legal prescale constants PRESC_8/16/32;
  - the default DATA_WIDTH.
- Sub-module edge_bit_counter:
  - inputs enable, clear and the latched Prescale;
  - outputs edge_count, bit_count and a bit_end pulse.
- The FSM, checks and strobes live in uart_rx_ctrl.

## Test plan
- Prescale=8, 8N1, byte 0xA5 LSB first -> deser_en at 8 bit ends with bit_count 1..8; data_valid 1 cycle after stop end; P_DATA=0xA5; no errors.
- Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x0F, parity bit 0 -> data_valid=1, par_err=0. Same frame with parity bit 1 -> par_err pulse at parity bit end, data_valid=0.
- Prescale=32, stop bit driven 0 -> stp_err pulse at stop end, data_valid=0, then IDLE.
- Low glitch of 3 cycles on RX_IN at Prescale=8 -> START then IDLE, no strobes, deser_en never asserted.
- Two back-to-back frames 0x3C and 0xC3 with no idle gap -> two data_valid strobes exactly (10×Prescale+1) cycles apart.
- RST low in the middle of DATA bit 4 -> all outputs 0 immediately; after release, a full frame 0x55 is received correctly.
